// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / data-port RAM arbiter:
// default geometry, owner FSM encodings and the address range check.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 15;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Read-owner FSM encodings; the state names which port gets the
    // read data returning from the RAM in the following cycle.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RD_IF = 2'b01;
    localparam logic [1:0] ST_RD_D  = 2'b10;

    // True when the byte address has set bits above the RAM word-address range.
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 32'd2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the single-port RAM side.
// master = requesters plus RAM model, slave = the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with one-cycle read latency.
// Data port has priority; a saturating starve counter lets a waiting fetch
// through after STARVE_LIMIT consecutive data grants. Grants are combinational
// so a new access can be issued every cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned     CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] starve_q;
    logic             rd_oob_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      d_rdata_q;

    logic             fetch_wins;
    logic             if_gnt;
    logic             d_gnt;
    logic [31:0]      sel_addr;
    logic             sel_oob;
    logic             if_rv;
    logic             d_rv;
    logic [31:0]      rd_data;

    // Arbitration: data first unless the fetch port has hit its starve limit.
    always_comb begin
        fetch_wins = bus.if_req && (!bus.d_req || starve_q == CNT_MAX);
        if_gnt     = !reset && fetch_wins;
        d_gnt      = !reset && bus.d_req && !fetch_wins;
        sel_addr   = if_gnt ? bus.if_addr : bus.d_addr;
        sel_oob    = addr_oob(sel_addr, ADDR_W);
        state_d    = ST_IDLE;
        if (if_gnt) begin
            state_d = ST_RD_IF;
        end else if (d_gnt && !bus.d_we) begin
            state_d = ST_RD_D;
        end
    end

    // RAM request side: address/write strobes only for a granted access.
    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.d_gnt     = d_gnt;
        bus.mem_addr  = '0;
        bus.mem_wen   = '0;
        bus.mem_wdata = '0;
        if (if_gnt || d_gnt) begin
            bus.mem_addr = sel_addr[ADDR_W+1:2];
        end
        if (d_gnt && bus.d_we) begin
            bus.mem_wdata = bus.d_wdata;
            if (!sel_oob) begin
                bus.mem_wen = bus.d_be;
            end
        end
    end

    // Read return: RAM data is routed straight to the owner in the cycle it
    // arrives; the registered copy only serves as the hold value afterwards.
    always_comb begin
        if_rv         = (state_q == ST_RD_IF) && !reset;
        d_rv          = (state_q == ST_RD_D) && !reset;
        rd_data       = rd_oob_q ? '0 : bus.mem_rdata;
        bus.if_rvalid = if_rv;
        bus.d_rvalid  = d_rv;
        bus.if_rdata  = if_rv ? rd_data : if_rdata_q;
        bus.d_rdata   = d_rv ? rd_data : d_rdata_q;
    end

    // Owner FSM, starve counter and read-data hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            rd_oob_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_oob_q   <= sel_oob;
            if_rdata_q <= bus.if_rdata;
            d_rdata_q  <= bus.d_rdata;
            if (!bus.if_req || if_gnt) begin
                starve_q <= '0;
            end else if (d_gnt && starve_q != CNT_MAX) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, directed multi-cycle
// sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW    = 15;
    localparam int unsigned SL    = 4;
    localparam int unsigned WORDS = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: byte writes, registered read.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wen[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model state
    logic [31:0] sb [WORDS];
    int unsigned m_cnt;
    logic        m_pif, m_pd;
    logic [31:0] m_pdata, m_if_last, m_d_last;

    int checks = 0;
    int failures = 0;

    // Last sampled DUT outputs
    logic          a_ig, a_dg, a_irv, a_drv;
    logic [3:0]    a_wen;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata, a_ird, a_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, predict, sample at negedge, compare, update model.
    task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] daddr, input logic [31:0] dwdata);
        logic        fw, e_ig, e_dg, oob, e_irv, e_drv;
        logic [31:0] gaddr;
        logic [3:0]  e_wen;
        int unsigned word;
        reset       = rst;
        bus.if_req  = ireq;
        bus.if_addr = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
        fw    = ireq && (!dreq || m_cnt == SL);
        e_ig  = !rst && fw;
        e_dg  = !rst && dreq && !fw;
        gaddr = e_ig ? iaddr : daddr;
        oob   = (gaddr >> 2) >= WORDS;
        word  = (gaddr >> 2) % WORDS;
        e_wen = (e_dg && dwe && !oob) ? dbe : 4'h0;
        e_irv = m_pif && !rst;
        e_drv = m_pd && !rst;
        @(negedge clk);
        a_ig = bus.if_gnt;  a_dg = bus.d_gnt;
        a_wen = bus.mem_wen; a_addr = bus.mem_addr; a_wdata = bus.mem_wdata;
        a_irv = bus.if_rvalid; a_drv = bus.d_rvalid;
        a_ird = bus.if_rdata;  a_drd = bus.d_rdata;
        chk("if_gnt", 32'(a_ig), 32'(e_ig));
        chk("d_gnt", 32'(a_dg), 32'(e_dg));
        chk("mem_wen", 32'(a_wen), 32'(e_wen));
        chk("mem_addr", 32'(a_addr), (e_ig || e_dg) ? word : 32'd0);
        if (e_dg && dwe) chk("mem_wdata", a_wdata, dwdata);
        chk("if_rvalid", 32'(a_irv), 32'(e_irv));
        chk("d_rvalid", 32'(a_drv), 32'(e_drv));
        chk("if_rdata", a_ird, e_irv ? m_pdata : m_if_last);
        chk("d_rdata", a_drd, e_drv ? m_pdata : m_d_last);
        if (e_irv) m_if_last = m_pdata;
        if (e_drv) m_d_last = m_pdata;
        if (rst) begin
            m_cnt = 0; m_pif = 1'b0; m_pd = 1'b0;
            m_if_last = '0; m_d_last = '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (e_wen[b]) sb[word][b*8 +: 8] = dwdata[b*8 +: 8];
            end
            m_pif = e_ig;
            m_pd  = e_dg && !dwe;
            if (m_pif || m_pd) m_pdata = oob ? 32'h0 : sb[word];
            if (!ireq || e_ig) m_cnt = 0;
            else if (e_dg && m_cnt < SL) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] gen_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return 32'h0002_0000 | ($urandom() & 32'hFFFF_003F);
        if (r == 1) return 32'h0001_FFFC;
        return ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        e_ig;
        logic        e_dg;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[8];

    logic        rq_i, rq_d, rwe;
    logic [31:0] ra_i, ra_d, rwd;
    logic [3:0]  rbe;
    logic [7:0]  gpat_d, gpat_i;

    initial begin
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,         32'h0,        1'b0, 1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 32'h10,       1'b0, 1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 1'b0, 4'h0, 32'h4};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'hF, 32'h20,        32'hCAFE0001, 1'b0, 1'b1, 4'hF, 32'h8};
        vecs[3] = '{1'b1, 32'h8,        1'b1, 1'b0, 4'h0, 32'h44,        32'h0,        1'b0, 1'b1, 4'h0, 32'h11};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3, 32'h0002_0000, 32'h1234,     1'b0, 1'b1, 4'h0, 32'h0};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h5, 32'h7,         32'hA5A5A5A5, 1'b0, 1'b1, 4'h5, 32'h1};
        vecs[6] = '{1'b1, 32'h0001_FFFC, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 4'h0, 32'h7FFF};
        vecs[7] = '{1'b1, 32'h4,        1'b1, 1'b1, 4'hA, 32'h30,        32'h0BADF00D, 1'b0, 1'b1, 4'hA, 32'hC};

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            ram[i] = '0;
            sb[i]  = '0;
        end
        m_cnt = 0; m_pif = 1'b0; m_pd = 1'b0;
        m_pdata = '0; m_if_last = '0; m_d_last = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: no grants, no rvalid, rdata cleared
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 4'hF, 32'h8, 32'h1);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_starve", 32'(dut.starve_q), 32'h0);

        // Table vectors, each followed by an idle cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                 vecs[i].dbe, vecs[i].daddr, vecs[i].dwdata);
            chk($sformatf("vec%0d_ig", i), 32'(a_ig), 32'(vecs[i].e_ig));
            chk($sformatf("vec%0d_dg", i), 32'(a_dg), 32'(vecs[i].e_dg));
            chk($sformatf("vec%0d_wen", i), 32'(a_wen), 32'(vecs[i].e_wen));
            chk($sformatf("vec%0d_addr", i), 32'(a_addr), vecs[i].e_addr);
            idle();
        end

        // Write 25 to address 100, read it back
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'd100, 32'd25);
        chk("wr100_wen", 32'(a_wen), 32'hF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'd100, 32'h0);
        chk("rd100_gnt", 32'(a_dg), 32'h1);
        idle();
        chk("rd100_rvalid", 32'(a_drv), 32'h1);
        chk("rd100_data", a_drd, 32'd25);

        // Simultaneous fetch and data read
        step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'd100, 32'h0);
        chk("both_n_dg", 32'(a_dg), 32'h1);
        chk("both_n_ig", 32'(a_ig), 32'h0);
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("both_n1_ig", 32'(a_ig), 32'h1);
        chk("both_n1_drv", 32'(a_drv), 32'h1);
        idle();
        chk("both_n2_irv", 32'(a_irv), 32'h1);
        chk("both_n2_ird", a_ird, 32'hCAFE0001);

        // Starvation: 8 cycles of data reads with fetch pending
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'(k * 4), 32'h0);
            gpat_d[k] = a_dg;
            gpat_i[k] = a_ig;
        end
        chk("starve_dgnt_pattern", 32'(gpat_d), 32'hEF);
        chk("starve_ignt_pattern", 32'(gpat_i), 32'h10);
        idle();
        idle();

        // Reset in the cycle after a fetch grant drops the read
        step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rstseq_ig", 32'(a_ig), 32'h1);
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rstseq_irv_in_rst", 32'(a_irv), 32'h0);
        chk("rstseq_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rstseq_starve", 32'(dut.starve_q), 32'h0);
        idle();
        chk("rstseq_irv_after", 32'(a_irv), 32'h0);
        chk("rstseq_ird_after", a_ird, 32'h0);

        // Out-of-range write suppressed, read returns zero (word 0 preloaded)
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h55);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0002_0000, 32'd7);
        chk("oob_wen", 32'(a_wen), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0002_0000, 32'h0);
        idle();
        chk("oob_rvalid", 32'(a_drv), 32'h1);
        chk("oob_rdata", a_drd, 32'h0);

        // Back-to-back fetches of words 0,1,2
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h11);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h22);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h33);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_rv0", 32'(a_irv), 32'h1);
        chk("b2b_d0", a_ird, 32'h11);
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_rv1", 32'(a_irv), 32'h1);
        chk("b2b_d1", a_ird, 32'h22);
        idle();
        chk("b2b_rv2", 32'(a_irv), 32'h1);
        chk("b2b_d2", a_ird, 32'h33);
        idle();
        chk("b2b_hold", a_ird, 32'h33);

        // Randomized traffic; requests held until granted
        rq_i = 1'b0; rq_d = 1'b0;
        ra_i = '0; ra_d = '0; rwe = 1'b0; rbe = '0; rwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!rq_i && $urandom_range(0, 2) != 0) begin
                rq_i = 1'b1;
                ra_i = gen_addr();
            end
            if (!rq_d && $urandom_range(0, 3) != 0) begin
                rq_d = 1'b1;
                ra_d = gen_addr();
                rwe  = ($urandom_range(0, 1) == 1);
                rbe  = 4'($urandom_range(0, 15));
                rwd  = $urandom();
            end
            step(($urandom_range(0, 63) == 0), rq_i, ra_i, rq_d, rwe, rbe, ra_d, rwd);
            if (a_ig) rq_i = 1'b0;
            if (a_dg) rq_d = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, meaning: word-address width driven to the single-port RAM (128 kB).
REQ-002 Parameter STARVE_LIMIT, default 4, meaning: consecutive data grants allowed while a fetch waits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch request (read-only).
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  if_rdata valid.
REQ-009 if_rdata  output  32  fetched instruction.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_be  input  4  write byte enables.
REQ-013 d_addr  input  32  data byte address.
REQ-014 d_wdata  input  32  write data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  d_rdata valid (reads only).
REQ-017 d_rdata  output  32  read data.
REQ-018 mem_wen  output  4  RAM byte write enables.
REQ-019 mem_addr  output  ADDR_W  RAM word address.
REQ-020 mem_wdata  output  32  RAM write data.
REQ-021 mem_rdata  input  32  RAM read data, valid one cycle after address.

Function
REQ-022 At most one of if_gnt/d_gnt SHALL be high per cycle; grant is combinational in the request cycle.
REQ-023 Granted request SHALL drive mem_addr = addr[ADDR_W+1:2] in the grant cycle; addr[1:0] ignored.
REQ-024 Granted write SHALL drive mem_wen = d_be and mem_wdata = d_wdata in the grant cycle; write completes that cycle, no rvalid.
REQ-025 Granted read SHALL produce rvalid on the owning port exactly one cycle later, rdata = mem_rdata; rdata otherwise holds last value.
REQ-026 Back-to-back grants SHALL be allowed every cycle (full throughput, no bubbles).
REQ-027 Priority: data over fetch, except when starve counter == STARVE_LIMIT and if_req high, then fetch wins.
REQ-028 Starve counter: increments on each d_gnt while if_req high, saturates at STARVE_LIMIT, clears on if_gnt or when if_req low.
REQ-029 Owner FSM states IDLE, RD_IF, RD_D: next state RD_IF on fetch grant, RD_D on data read grant, IDLE otherwise (incl. data write).
REQ-030 Address with bits [31:ADDR_W+2] nonzero: granted normally, write suppressed (mem_wen = 0), read returns 32'h0.
REQ-031 No request pending: mem_wen = 0, mem_addr = 0.
REQ-032 Requesters SHALL hold req/addr/wdata stable until gnt; arbiter makes no other assumption.

Reset
REQ-033 Reset SHALL set FSM = IDLE, starve counter = 0, if_rvalid = d_rvalid = 0, if_rdata = d_rdata = 0.
REQ-034 Reset asserted while a read is outstanding SHALL drop it: no rvalid in the following cycle.
REQ-035 During reset, grants SHALL be 0 and mem_wen = 0.

Structure
REQ-036 Shared package/header SHALL hold FSM state encodings, default ADDR_W and STARVE_LIMIT.
REQ-037 Single flat module; no sub-module; the RAM (spram128kB) stays outside, instantiated by the parent.

Verification
REQ-038 Data write d_addr=100, d_wdata=25, d_be=4'hF, then read 100 -> mem_wen=4'hF in grant cycle; d_rvalid next cycle after read with d_rdata=25.
REQ-039 if_req and d_req (read) same cycle -> d_gnt cycle N, if_gnt cycle N+1, d_rvalid N+1, if_rvalid N+2.
REQ-040 d_req held 8 cycles with if_req high -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt resumes cycle 5.
REQ-041 Reset pulsed in cycle after fetch grant -> if_rvalid stays 0, FSM IDLE, counter 0.
REQ-042 Write d_addr=32'h0002_0000 data 7 -> mem_wen=0; read same address -> d_rdata=0.
REQ-043 Alternating fetch reads of addresses 0,4,8 every cycle -> if_rvalid high 3 consecutive cycles, data in address order.
